// File: rtl/goodness_ema_tracker.sv
// Per-core goodness tracker: ReLU-mean/max beat reduction, warm-up-corrected fixed-point EMA, hysteretic flag.
// Optional peak-since-clear tracking is compiled in with `define GOODNESS_PEAK_EN.
module goodness_ema_tracker #(
    parameter int CORE_NUM            = 4,
    parameter int POST_NEUR_PARALLEL  = 8,
    parameter int POST_NEUR_MEM_WIDTH = 13,
    parameter int GOODNESS_WIDTH      = 20,
    parameter int FRAC_BITS           = 4,
    parameter int SHIFT_WIDTH         = 3,
    parameter int CNT_WIDTH           = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]                                  cfg_shift,
    input  logic [GOODNESS_WIDTH-1:0]                               cfg_threshold,
    input  logic [GOODNESS_WIDTH-1:0]                               cfg_hyst,
    input  logic [CORE_NUM-1:0]                                     core_valid,
    output logic [CORE_NUM-1:0]                                     core_ready,
    input  logic [CORE_NUM-1:0]                                     core_clear_goodness,
    input  logic [CORE_NUM*POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH-1:0] core_mem_bus,
    output logic [CORE_NUM*GOODNESS_WIDTH-1:0]                      avg_mem_bus,
    output logic [CORE_NUM-1:0]                                     avg_valid,
    output logic [CORE_NUM-1:0]                                     goodness_flag,
    output logic [CORE_NUM*GOODNESS_WIDTH-1:0]                      peak_mem_bus
);

    localparam int LOG_P = $clog2(POST_NEUR_PARALLEL);
    localparam int X_W   = POST_NEUR_MEM_WIDTH - 1;
    localparam int SUM_W = X_W + LOG_P;
    localparam int ACC_W = GOODNESS_WIDTH + FRAC_BITS;

    function automatic logic [X_W-1:0] relu(input logic signed [POST_NEUR_MEM_WIDTH-1:0] m);
        if (m < 0)
            return '0;
        return m[X_W-1:0];
    endfunction

    // Warm-up correction: early samples use a faster decay so the average is unbiased.
    function automatic logic [SHIFT_WIDTH-1:0] eff_shift(input logic [CNT_WIDTH-1:0]   cnt,
                                                         input logic [SHIFT_WIDTH-1:0] shift);
        logic [CNT_WIDTH:0] n;
        int                 lg;
        n  = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
        lg = 0;
        for (int i = 0; i <= CNT_WIDTH; i++)
            if (n[i])
                lg = i;
        if (lg < int'(shift))
            return SHIFT_WIDTH'(lg);
        return shift;
    endfunction

    function automatic logic [ACC_W-1:0] ema_step(input logic [ACC_W-1:0]       e,
                                                  input logic [X_W-1:0]         x,
                                                  input logic [SHIFT_WIDTH-1:0] s);
        logic signed [ACC_W:0] diff;
        logic signed [ACC_W:0] sum;
        diff = $signed({1'b0, (ACC_W'(x) << FRAC_BITS)}) - $signed({1'b0, e});
        sum  = $signed({1'b0, e}) + (diff >>> s);
        return ACC_W'(sum);
    endfunction

    function automatic logic [GOODNESS_WIDTH-1:0] sat_add(input logic [GOODNESS_WIDTH-1:0] a,
                                                          input logic [GOODNESS_WIDTH-1:0] b);
        logic [GOODNESS_WIDTH:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t[GOODNESS_WIDTH])
            return '1;
        return t[GOODNESS_WIDTH-1:0];
    endfunction

    function automatic logic [GOODNESS_WIDTH-1:0] sat_sub(input logic [GOODNESS_WIDTH-1:0] a,
                                                          input logic [GOODNESS_WIDTH-1:0] b);
        if (a < b)
            return '0;
        return a - b;
    endfunction

    logic [GOODNESS_WIDTH-1:0] band_hi;
    logic [GOODNESS_WIDTH-1:0] band_lo;

    assign band_hi    = sat_add(cfg_threshold, cfg_hyst);
    assign band_lo    = sat_sub(cfg_threshold, cfg_hyst);
    assign core_ready = {CORE_NUM{rst_n}} & ~core_clear_goodness;

    for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
        logic [SUM_W-1:0]          sum_p0;
        logic [X_W-1:0]            max_p0;
        logic [X_W-1:0]            x_p0;
        logic                      accept_p0;
        logic                      clear;
        logic                      vld_p1;
        logic [X_W-1:0]            x_p1;
        logic [ACC_W-1:0]          e_p2;
        logic [ACC_W-1:0]          e_next;
        logic [CNT_WIDTH-1:0]      cnt_p2;
        logic                      vld_p2;
        logic [GOODNESS_WIDTH-1:0] avg_p2;
        logic                      flag_p3;

        assign clear     = core_clear_goodness[c];
        assign accept_p0 = core_valid[c] & core_ready[c];

        always_comb begin : p_reduce
            logic [X_W-1:0] v;
            v      = '0;
            sum_p0 = '0;
            max_p0 = '0;
            for (int n = 0; n < POST_NEUR_PARALLEL; n++) begin
                v      = relu($signed(core_mem_bus[(c*POST_NEUR_PARALLEL + n)*POST_NEUR_MEM_WIDTH +: POST_NEUR_MEM_WIDTH]));
                sum_p0 = sum_p0 + SUM_W'(v);
                if (v > max_p0)
                    max_p0 = v;
            end
            x_p0 = cfg_mode ? max_p0 : X_W'(sum_p0 >> LOG_P);
        end

        // Stage 1: register the reduced beat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1 <= 1'b0;
                x_p1   <= '0;
            end else if (clear) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= accept_p0;
                if (accept_p0)
                    x_p1 <= x_p0;
            end
        end

        assign e_next = ema_step(e_p2, x_p1, eff_shift(cnt_p2, cfg_shift));
        assign avg_p2 = e_p2[ACC_W-1:FRAC_BITS];

        // Stage 2: EMA update; clear discards any update pending this cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                e_p2   <= '0;
                cnt_p2 <= '0;
                vld_p2 <= 1'b0;
            end else if (clear) begin
                e_p2   <= '0;
                cnt_p2 <= '0;
                vld_p2 <= 1'b0;
            end else if (vld_p1) begin
                e_p2   <= e_next;
                vld_p2 <= 1'b1;
                if (cnt_p2 != '1)
                    cnt_p2 <= cnt_p2 + CNT_WIDTH'(1);
            end else begin
                vld_p2 <= 1'b0;
            end
        end

        // Stage 3: hysteretic flag evaluated on each freshly published average
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flag_p3 <= 1'b0;
            end else if (clear) begin
                flag_p3 <= 1'b0;
            end else if (vld_p2) begin
                if (avg_p2 >= band_hi)
                    flag_p3 <= 1'b1;
                else if (avg_p2 < band_lo)
                    flag_p3 <= 1'b0;
            end
        end

        assign avg_mem_bus[c*GOODNESS_WIDTH +: GOODNESS_WIDTH] = avg_p2;
        assign avg_valid[c]     = vld_p2;
        assign goodness_flag[c] = flag_p3;

`ifdef GOODNESS_PEAK_EN
        logic [GOODNESS_WIDTH-1:0] peak_p2;
        logic [GOODNESS_WIDTH-1:0] avg_next;

        assign avg_next = e_next[ACC_W-1:FRAC_BITS];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                peak_p2 <= '0;
            else if (clear)
                peak_p2 <= '0;
            else if (vld_p1 && (avg_next > peak_p2))
                peak_p2 <= avg_next;
        end

        assign peak_mem_bus[c*GOODNESS_WIDTH +: GOODNESS_WIDTH] = peak_p2;
`endif
    end

`ifndef GOODNESS_PEAK_EN
    assign peak_mem_bus = '0;
`endif

endmodule
